// File: rtl/mips_alu_unit.sv
// mips_alu_unit: single-cycle MIPS integer ALU with operation decode, zero/overflow flags and HI/LO.
// Define ALU_MULDIV_EN to build the HI/LO pair and the mult/div/mfhi/mflo/mthi/mtlo operations.
module mips_alu_unit (
   input  logic        iCLK,
   input  logic        iRST,
   input  logic [1:0]  iALUOp,
   input  logic [5:0]  iOpcode,
   input  logic [5:0]  iFunct,
   input  logic [31:0] iA,
   input  logic [31:0] iB,
   input  logic [4:0]  iShamt,
   output logic [31:0] oALUresult,
   output logic        oZero,
   output logic        oOverflow,
   output logic [4:0]  oALUCtrl
);
   typedef enum logic [4:0] {
      OP_NOP, OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_NOR,
      OP_SLT, OP_SLTU, OP_SLL, OP_SRL, OP_SRA, OP_SLLV, OP_SRLV, OP_SRAV, OP_LUI,
      OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU
   } op_e;

   op_e         w_op;
   logic [31:0] w_sum, w_diff, w_hi, w_lo;

   assign w_sum  = iA + iB;
   assign w_diff = iA - iB;

   always_comb begin
      w_op = OP_NOP;
      case (iALUOp)
         2'b00: w_op = OP_ADDU;
         2'b01: w_op = OP_SUBU;
         2'b10:
            case (iFunct)
               6'h00: w_op = OP_SLL;
               6'h02: w_op = OP_SRL;
               6'h03: w_op = OP_SRA;
               6'h04: w_op = OP_SLLV;
               6'h06: w_op = OP_SRLV;
               6'h07: w_op = OP_SRAV;
               6'h08: w_op = OP_ADDU;
`ifdef ALU_MULDIV_EN
               6'h10: w_op = OP_MFHI;
               6'h11: w_op = OP_MTHI;
               6'h12: w_op = OP_MFLO;
               6'h13: w_op = OP_MTLO;
               6'h18: w_op = OP_MULT;
               6'h19: w_op = OP_MULTU;
               6'h1A: w_op = OP_DIV;
               6'h1B: w_op = OP_DIVU;
`endif
               6'h20: w_op = OP_ADD;
               6'h21: w_op = OP_ADDU;
               6'h22: w_op = OP_SUB;
               6'h23: w_op = OP_SUBU;
               6'h24: w_op = OP_AND;
               6'h25: w_op = OP_OR;
               6'h26: w_op = OP_XOR;
               6'h27: w_op = OP_NOR;
               6'h2A: w_op = OP_SLT;
               6'h2B: w_op = OP_SLTU;
               default: w_op = OP_NOP;
            endcase
         default:
            case (iOpcode)
               6'h08: w_op = OP_ADD;
               6'h09: w_op = OP_ADDU;
               6'h0A: w_op = OP_SLT;
               6'h0B: w_op = OP_SLTU;
               6'h0C: w_op = OP_AND;
               6'h0D: w_op = OP_OR;
               6'h0E: w_op = OP_XOR;
               6'h0F: w_op = OP_LUI;
               default: w_op = OP_NOP;
            endcase
      endcase
   end

`ifdef ALU_MULDIV_EN
   logic [31:0] r_hi, r_lo, w_a_abs, w_b_abs, w_qm, w_rm;
   logic [31:0] w_div_hi, w_div_lo, w_divu_hi, w_divu_lo;
   logic [63:0] w_prod_s, w_prod_u;
   assign w_prod_s = {{32{iA[31]}}, iA} * {{32{iB[31]}}, iB};
   assign w_prod_u = {32'b0, iA} * {32'b0, iB};
   // Signed divide on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
   assign w_a_abs   = iA[31] ? -iA : iA;
   assign w_b_abs   = iB[31] ? -iB : iB;
   assign w_qm      = w_a_abs / w_b_abs;
   assign w_rm      = w_a_abs % w_b_abs;
   assign w_div_lo  = (iB == '0) ? '1 : (iA[31] ^ iB[31]) ? -w_qm : w_qm;
   assign w_div_hi  = (iB == '0) ? iA : iA[31] ? -w_rm : w_rm;
   assign w_divu_lo = (iB == '0) ? '1 : iA / iB;
   assign w_divu_hi = (iB == '0) ? iA : iA % iB;
   assign w_hi      = r_hi;
   assign w_lo      = r_lo;

   always_ff @(posedge iCLK)
      if (iRST) begin
         r_hi <= '0;
         r_lo <= '0;
      end else
         case (w_op)
            OP_MTHI:  r_hi <= iA;
            OP_MTLO:  r_lo <= iA;
            OP_MULT:  {r_hi, r_lo} <= w_prod_s;
            OP_MULTU: {r_hi, r_lo} <= w_prod_u;
            OP_DIV:   {r_hi, r_lo} <= {w_div_hi, w_div_lo};
            OP_DIVU:  {r_hi, r_lo} <= {w_divu_hi, w_divu_lo};
            default: ;
         endcase
`else
   logic w_unused;
   assign w_unused = &{1'b0, iCLK, iRST};
   assign w_hi     = '0;
   assign w_lo     = '0;
`endif

   always_comb begin
      oALUresult = '0;
      case (w_op)
         OP_ADD, OP_ADDU: oALUresult = w_sum;
         OP_SUB, OP_SUBU: oALUresult = w_diff;
         OP_AND:          oALUresult = iA & iB;
         OP_OR:           oALUresult = iA | iB;
         OP_XOR:          oALUresult = iA ^ iB;
         OP_NOR:          oALUresult = ~(iA | iB);
         OP_SLT:          oALUresult = {31'b0, $signed(iA) < $signed(iB)};
         OP_SLTU:         oALUresult = {31'b0, iA < iB};
         OP_SLL:          oALUresult = iB << iShamt;
         OP_SRL:          oALUresult = iB >> iShamt;
         OP_SRA:          oALUresult = $signed(iB) >>> iShamt;
         OP_SLLV:         oALUresult = iB << iA[4:0];
         OP_SRLV:         oALUresult = iB >> iA[4:0];
         OP_SRAV:         oALUresult = $signed(iB) >>> iA[4:0];
         OP_LUI:          oALUresult = {iB[15:0], 16'h0};
         OP_MFHI:         oALUresult = w_hi;
         OP_MFLO:         oALUresult = w_lo;
         OP_MTHI, OP_MTLO: oALUresult = iA;
         default:         oALUresult = '0;
      endcase
   end

   assign oZero     = (oALUresult == '0);
   assign oOverflow = ((w_op == OP_ADD) & (iA[31] == iB[31]) & (w_sum[31] != iA[31])) |
                      ((w_op == OP_SUB) & (iA[31] != iB[31]) & (w_diff[31] != iA[31]));
   assign oALUCtrl  = w_op;
endmodule

// File: tb/tb_mips_alu_unit.sv
// tb_mips_alu_unit: directed vector table, HI/LO sequences and a randomized run against a reference model.
module tb_mips_alu_unit;
`ifdef ALU_MULDIV_EN
   localparam bit MD = 1'b1;
`else
   localparam bit MD = 1'b0;
`endif
   localparam longint MAXI = 2147483647;
   localparam longint MINI = -MAXI - 1;

   logic        iCLK = 1'b0, iRST = 1'b1;
   logic [1:0]  iALUOp = '0;
   logic [5:0]  iOpcode = '0, iFunct = '0;
   logic [31:0] iA = '0, iB = '0;
   logic [4:0]  iShamt = '0;
   logic [31:0] oALUresult;
   logic        oZero, oOverflow;
   logic [4:0]  oALUCtrl;

   int checks = 0, errors = 0;
   logic [31:0] s_r;
   logic        s_z, s_ov;
   logic [31:0] m_hi = '0, m_lo = '0;

   mips_alu_unit dut (
      .iCLK(iCLK), .iRST(iRST), .iALUOp(iALUOp), .iOpcode(iOpcode), .iFunct(iFunct),
      .iA(iA), .iB(iB), .iShamt(iShamt), .oALUresult(oALUresult), .oZero(oZero),
      .oOverflow(oOverflow), .oALUCtrl(oALUCtrl)
   );

   always #5 iCLK = ~iCLK;

   typedef struct {
      logic [1:0]  op;
      logic [5:0]  opc;
      logic [5:0]  fn;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  sh;
      logic [31:0] r;
      logic        ov;
   } vec_t;

   vec_t tbl[14];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, got, exp);
      end
   endtask

   task automatic run(input logic [1:0] op, input logic [5:0] opc, input logic [5:0] fn,
                      input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh, input logic rst);
      iALUOp = op; iOpcode = opc; iFunct = fn; iA = a; iB = b; iShamt = sh; iRST = rst;
      @(negedge iCLK);
      s_r = oALUresult; s_z = oZero; s_ov = oOverflow;
      @(posedge iCLK);
      #1 iRST = 1'b0;
   endtask

   function automatic void model(input logic [1:0] op, input logic [5:0] opc, input logic [5:0] fn,
                                 input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                                 input logic [31:0] hi, input logic [31:0] lo,
                                 output logic [31:0] r, output logic ov, output logic [31:0] nh,
                                 output logic [31:0] nl);
      logic signed [31:0] sa, sb;
      longint s, q, m;
      logic [63:0] pu;
      sa = a; sb = b; r = '0; ov = 1'b0; nh = hi; nl = lo;
      if (op == 2'd0) r = a + b;
      else if (op == 2'd1) r = a - b;
      else if (op == 2'd2) begin
         case (fn)
            6'h00: r = b << sh;
            6'h02: r = b >> sh;
            6'h03: r = sb >>> sh;
            6'h04: r = b << a[4:0];
            6'h06: r = b >> a[4:0];
            6'h07: r = sb >>> a[4:0];
            6'h08, 6'h21: r = a + b;
            6'h20: begin r = a + b; s = longint'(sa) + longint'(sb); ov = (s > MAXI) || (s < MINI); end
            6'h22: begin r = a - b; s = longint'(sa) - longint'(sb); ov = (s > MAXI) || (s < MINI); end
            6'h23: r = a - b;
            6'h24: r = a & b;
            6'h25: r = a | b;
            6'h26: r = a ^ b;
            6'h27: r = ~(a | b);
            6'h2A: r = (sa < sb) ? 32'd1 : 32'd0;
            6'h2B: r = (a < b) ? 32'd1 : 32'd0;
            6'h10: r = hi;
            6'h12: r = lo;
            6'h11: begin r = a; nh = a; end
            6'h13: begin r = a; nl = a; end
            6'h18: begin s = longint'(sa) * longint'(sb); nh = s[63:32]; nl = s[31:0]; end
            6'h19: begin pu = 64'(a) * 64'(b); nh = pu[63:32]; nl = pu[31:0]; end
            6'h1A:
               if (b == 0) begin nl = 32'hFFFFFFFF; nh = a; end
               else begin
                  q = longint'(sa) / longint'(sb); m = longint'(sa) % longint'(sb);
                  nl = q[31:0]; nh = m[31:0];
               end
            6'h1B:
               if (b == 0) begin nl = 32'hFFFFFFFF; nh = a; end
               else begin nl = a / b; nh = a % b; end
            default: r = '0;
         endcase
         if (!MD && (fn inside {6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B})) begin
            r = '0; nh = hi; nl = lo;
         end
      end else begin
         case (opc)
            6'h08: begin r = a + b; s = longint'(sa) + longint'(sb); ov = (s > MAXI) || (s < MINI); end
            6'h09: r = a + b;
            6'h0A: r = (sa < sb) ? 32'd1 : 32'd0;
            6'h0B: r = (a < b) ? 32'd1 : 32'd0;
            6'h0C: r = a & b;
            6'h0D: r = a | b;
            6'h0E: r = a ^ b;
            6'h0F: r = {b[15:0], 16'h0000};
            default: r = '0;
         endcase
      end
   endfunction

   function automatic logic [31:0] pick32();
      case ($urandom_range(0, 7))
         0: return 32'h7FFFFFFF;
         1: return 32'h80000000;
         2: return 32'hFFFFFFFF;
         3: return 32'h0;
         4: return 32'($urandom_range(0, 40));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [5:0] fl[$];
      logic [5:0] ol[$];
      logic [1:0] op;
      logic [5:0] opc, fn;
      logic [31:0] a, b, er, nh, nl;
      logic [4:0] sh;
      logic eov, rst;
      fl = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h10, 6'h11, 6'h12, 6'h13, 6'h18,
             6'h19, 6'h1A, 6'h1B, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
      ol = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
      tbl[0]  = '{2'd2, 6'h00, 6'h20, 32'h7FFFFFFF, 32'h1,        5'd0, 32'h80000000, 1'b1};
      tbl[1]  = '{2'd2, 6'h00, 6'h21, 32'h7FFFFFFF, 32'h1,        5'd0, 32'h80000000, 1'b0};
      tbl[2]  = '{2'd1, 6'h00, 6'h00, 32'h1234,     32'h1234,     5'd0, 32'h0,        1'b0};
      tbl[3]  = '{2'd1, 6'h00, 6'h00, 32'h1234,     32'h1235,     5'd0, 32'hFFFFFFFF, 1'b0};
      tbl[4]  = '{2'd2, 6'h00, 6'h2A, 32'hFFFFFFFF, 32'h1,        5'd0, 32'h1,        1'b0};
      tbl[5]  = '{2'd2, 6'h00, 6'h2B, 32'hFFFFFFFF, 32'h1,        5'd0, 32'h0,        1'b0};
      tbl[6]  = '{2'd2, 6'h00, 6'h03, 32'h0,        32'h80000000, 5'd4, 32'hF8000000, 1'b0};
      tbl[7]  = '{2'd2, 6'h00, 6'h06, 32'd36,       32'hF0,       5'd0, 32'h0F,       1'b0};
      tbl[8]  = '{2'd3, 6'h0F, 6'h00, 32'h0,        32'h0000ABCD, 5'd0, 32'hABCD0000, 1'b0};
      tbl[9]  = '{2'd3, 6'h0D, 6'h00, 32'hF0,       32'h0F,       5'd0, 32'hFF,       1'b0};
      tbl[10] = '{2'd2, 6'h00, 6'h22, 32'h80000000, 32'h1,        5'd0, 32'h7FFFFFFF, 1'b1};
      tbl[11] = '{2'd2, 6'h00, 6'h3F, 32'h5,        32'h6,        5'd0, 32'h0,        1'b0};
      tbl[12] = '{2'd3, 6'h08, 6'h00, 32'h80000000, 32'hFFFFFFFF, 5'd0, 32'h7FFFFFFF, 1'b1};
      tbl[13] = '{2'd0, 6'h00, 6'h00, 32'h7FFFFFFF, 32'h1,        5'd0, 32'h80000000, 1'b0};

      run(2'd0, 6'h0, 6'h0, 32'h0, 32'h0, 5'd0, 1'b1);
      run(2'd0, 6'h0, 6'h0, 32'h0, 32'h0, 5'd0, 1'b0);
      chk("rst_result", s_r, 32'h0);
      chk("rst_zero", {31'b0, s_z}, 32'h1);
      chk("rst_ovf", {31'b0, s_ov}, 32'h0);
      run(2'd2, 6'h0, 6'h10, 32'h0, 32'h0, 5'd0, 1'b0);
      chk("rst_hi", s_r, 32'h0);
      run(2'd2, 6'h0, 6'h12, 32'h0, 32'h0, 5'd0, 1'b0);
      chk("rst_lo", s_r, 32'h0);

      for (int i = 0; i < 14; i++) begin
         run(tbl[i].op, tbl[i].opc, tbl[i].fn, tbl[i].a, tbl[i].b, tbl[i].sh, 1'b0);
         chk($sformatf("vec%0d_result", i), s_r, tbl[i].r);
         chk($sformatf("vec%0d_ovf", i), {31'b0, s_ov}, {31'b0, tbl[i].ov});
         chk($sformatf("vec%0d_zero", i), {31'b0, s_z}, {31'b0, tbl[i].r == 32'h0});
      end

      run(2'd2, 6'h0, 6'h18, 32'hFFFFFFFD, 32'd5, 5'd0, 1'b0);
      chk("mult_result", s_r, 32'h0);
      run(2'd2, 6'h0, 6'h10, 32'h0, 32'h0, 5'd0, 1'b0);
      chk("mult_hi", s_r, MD ? 32'hFFFFFFFF : 32'h0);
      run(2'd2, 6'h0, 6'h12, 32'h0, 32'h0, 5'd0, 1'b0);
      chk("mult_lo", s_r, MD ? 32'hFFFFFFF1 : 32'h0);
      run(2'd2, 6'h0, 6'h1A, 32'hFFFFFFF9, 32'd2, 5'd0, 1'b0);
      run(2'd2, 6'h0, 6'h12, 32'h0, 32'h0, 5'd0, 1'b0);
      chk("div_lo", s_r, MD ? 32'hFFFFFFFD : 32'h0);
      run(2'd2, 6'h0, 6'h10, 32'h0, 32'h0, 5'd0, 1'b0);
      chk("div_hi", s_r, MD ? 32'hFFFFFFFF : 32'h0);
      run(2'd2, 6'h0, 6'h1B, 32'd9, 32'd0, 5'd0, 1'b0);
      run(2'd2, 6'h0, 6'h12, 32'h0, 32'h0, 5'd0, 1'b0);
      chk("divu0_lo", s_r, MD ? 32'hFFFFFFFF : 32'h0);
      run(2'd2, 6'h0, 6'h10, 32'h0, 32'h0, 5'd0, 1'b0);
      chk("divu0_hi", s_r, MD ? 32'd9 : 32'h0);
      run(2'd2, 6'h0, 6'h1A, 32'h80000000, 32'hFFFFFFFF, 5'd0, 1'b0);
      run(2'd2, 6'h0, 6'h12, 32'h0, 32'h0, 5'd0, 1'b0);
      chk("divmin_lo", s_r, MD ? 32'h80000000 : 32'h0);
      run(2'd2, 6'h0, 6'h10, 32'h0, 32'h0, 5'd0, 1'b0);
      chk("divmin_hi", s_r, 32'h0);
      run(2'd2, 6'h0, 6'h11, 32'h55, 32'h0, 5'd0, 1'b0);
      chk("mthi_result", s_r, MD ? 32'h55 : 32'h0);
      run(2'd2, 6'h0, 6'h10, 32'h0, 32'h0, 5'd0, 1'b0);
      chk("mthi_hi", s_r, MD ? 32'h55 : 32'h0);
      run(2'd2, 6'h0, 6'h11, 32'h77, 32'h0, 5'd0, 1'b1);
      run(2'd2, 6'h0, 6'h10, 32'h0, 32'h0, 5'd0, 1'b0);
      chk("rst_clears_hi", s_r, 32'h0);
      run(2'd2, 6'h0, 6'h13, 32'h11, 32'h0, 5'd0, 1'b0);
      run(2'd2, 6'h0, 6'h12, 32'h0, 32'h0, 5'd0, 1'b0);
      chk("mtlo_lo1", s_r, MD ? 32'h11 : 32'h0);
      run(2'd2, 6'h0, 6'h13, 32'h22, 32'h0, 5'd0, 1'b0);
      run(2'd2, 6'h0, 6'h12, 32'h0, 32'h0, 5'd0, 1'b0);
      chk("mtlo_lo2", s_r, MD ? 32'h22 : 32'h0);

      run(2'd0, 6'h0, 6'h0, 32'h0, 32'h0, 5'd0, 1'b1);
      m_hi = '0; m_lo = '0;
      for (int i = 0; i < 600; i++) begin
         op  = 2'($urandom_range(0, 3));
         fn  = ($urandom_range(0, 9) == 0) ? 6'($urandom) : fl[$urandom_range(0, fl.size() - 1)];
         opc = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ol[$urandom_range(0, ol.size() - 1)];
         a = pick32(); b = pick32(); sh = 5'($urandom);
         rst = ($urandom_range(0, 24) == 0);
         model(op, opc, fn, a, b, sh, m_hi, m_lo, er, eov, nh, nl);
         run(op, opc, fn, a, b, sh, rst);
         chk($sformatf("rnd%0d_result op%0d opc%h fn%h a%h b%h", i, op, opc, fn, a, b), s_r, er);
         chk($sformatf("rnd%0d_ovf", i), {31'b0, s_ov}, {31'b0, eov});
         chk($sformatf("rnd%0d_zero", i), {31'b0, s_z}, {31'b0, er == 32'h0});
         m_hi = rst ? 32'h0 : nh;
         m_lo = rst ? 32'h0 : nl;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mips_alu_unit.md
# mips_alu_unit

Integer execute unit of the single-cycle MIPS datapath: decodes the main-control ALU operation class plus opcode/funct into an internal operation, computes the 32-bit result, zero and signed-overflow flags combinationally, and holds the HI/LO register pair written by multiply/divide. Sits between the register file/operand-B mux and the memory-address, branch and writeback paths.

## Interface
- No parameters.
- iCLK  input  1  clock; HI/LO update on rising edge.
- iRST  input  1  synchronous, active-high reset; clock iCLK.
- iALUOp  input  2  class: 00 add (load/store), 01 sub (branch compare), 10 R-type via iFunct, 11 immediate via iOpcode.
- iOpcode  input  6  instruction[31:26].
- iFunct  input  6  instruction[5:0].
- iA  input  32  operand A (rs).
- iB  input  32  operand B (rt or extended immediate, extension done upstream).
- iShamt  input  5  instruction[10:6].
- oALUresult  output  32  combinational result.
- oZero  output  1  oALUresult == 0.
- oOverflow  output  1  signed overflow of add/sub/addi only.
- oALUCtrl  output  5  decoded internal operation code (debug).

## Operation
- ALUOp 00 -> add; 01 -> sub (no overflow flag for either).
- ALUOp 10, funct (hex): 00 sll, 02 srl, 03 sra (shift iB by iShamt); 04 sllv, 06 srlv, 07 srav (shift iB by iA[4:0]); 08 jr -> add; 10 mfhi, 12 mflo (result = HI/LO); 11 mthi, 13 mtlo (result = iA, write HI/LO); 18 mult, 19 multu, 1A div, 1B divu (result 0, write HI/LO); 20 add, 21 addu, 22 sub, 23 subu, 24 and, 25 or, 26 xor, 27 nor, 2A slt, 2B sltu.
- ALUOp 11, opcode (hex): 08 addi, 09 addiu, 0A slti, 0B sltiu, 0C andi, 0D ori, 0E xori, 0F lui (result = iB[15:0] << 16).
- Undecoded funct/opcode -> result 0, no overflow, no HI/LO write.
- slt/slti signed compare, sltu/sltiu unsigned; result 32'd1 or 32'd0.
- Arithmetic is modulo 2^32. oOverflow = 1 only for add, sub, addi when signed result wraps (operand signs equal and result sign differs; for sub, A and ~B signs). addu/subu/addiu never flag.
- mult/multu: {HI,LO} = 64-bit signed/unsigned product.
- div/divu: LO = quotient, HI = remainder, signed truncates toward zero, remainder takes dividend sign. Divide by zero: LO = 32'hFFFFFFFF, HI = iA. Signed 0x80000000 / -1: LO = 0x80000000, HI = 0.

## Timing
- All outputs combinational from inputs and current HI/LO; zero latency.
- HI/LO written on rising iCLK when a write op is decoded; mfhi/mflo in the same cycle as a write return the old value.
- iRST: HI = LO = 0 at next edge, overrides any write in that cycle.
- oALUresult/oZero/oOverflow have no reset value of their own; with iALUOp=00, iA=iB=0 after reset: result 0, oZero 1, oOverflow 0.

## Configuration
- ALU_MULDIV_EN defined: HI/LO registers and mult/multu/div/divu/mfhi/mflo/mthi/mtlo implemented as above.
- Undefined: no HI/LO storage; those functs decode as undecoded (result 0, oOverflow 0); iCLK/iRST remain ports but are unused.

## Test plan
- ALUOp 10 funct 20, iA=0x7FFFFFFF, iB=1 -> result 0x80000000, oOverflow 1; same with funct 21 -> oOverflow 0.
- ALUOp 01, iA=iB=0x1234 -> result 0, oZero 1; iB=0x1235 -> oZero 0, result 0xFFFFFFFF.
- funct 2A iA=0xFFFFFFFF iB=1 -> 1; funct 2B same operands -> 0; funct 03 iB=0x80000000 iShamt=4 -> 0xF8000000; funct 06 iA=36 (low 5 bits 4), iB=0xF0 -> 0x0F.
- ALUOp 11 opcode 0F iB=0x0000ABCD -> 0xABCD0000; opcode 0D iA=0xF0 iB=0x0F -> 0xFF.
- (ALU_MULDIV_EN) mult iA=-3 iB=5, clock, mfhi -> 0xFFFFFFFF, mflo -> 0xFFFFFFF1; div iA=-7 iB=2 -> LO 0xFFFFFFFD, HI 0xFFFFFFFF; divu by 0 with iA=9 -> LO 0xFFFFFFFF, HI 9.
- mthi 0x55 then iRST for one cycle -> mfhi returns 0; mtlo and mflo in same cycle -> mflo shows pre-edge value.
